// File: rtl/lsu.sv
// Load/store unit: drives a word-only data memory port for one RV32I load/store at a time.
// Byte and halfword stores are done as read-modify-write.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic [XLEN-1:0]   r_addr, w_addr_nxt;
  logic [XLEN-1:0]   r_wdata, w_wdata_nxt;
  logic              r_req_ready, r_resp_valid, r_resp_mis, r_mem_we;
  logic              w_resp_valid_nxt, w_resp_mis_nxt, w_mem_we_nxt;
  logic [XLEN-1:0]   r_resp_rdata, r_mem_addr, r_mem_wdata;
  logic [XLEN-1:0]   w_resp_rdata_nxt, w_mem_addr_nxt, w_mem_wdata_nxt;
  logic              w_legal;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_ext, w_merge;

  // Legality of the incoming request: funct3 encoding and natural alignment
  always_comb begin
    w_legal = 1'b0;
    if (req_we) begin
      unique case (req_funct3)
        3'd0:    w_legal = 1'b1;
        3'd1:    w_legal = !req_addr[0];
        3'd2:    w_legal = (req_addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end else begin
      unique case (req_funct3)
        3'd0, 3'd4: w_legal = 1'b1;
        3'd1, 3'd5: w_legal = !req_addr[0];
        3'd2:       w_legal = (req_addr[1:0] == 2'b00);
        default:    w_legal = 1'b0;
      endcase
    end
  end

  // Lane extraction for loads and lane merge for SB/SH
  always_comb begin
    w_byte     = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_ext = '0;
    unique case (r_funct3)
      3'd0:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_ext = {{16{w_half[15]}}, w_half};
      3'd2:    w_load_ext = mem_rdata;
      3'd4:    w_load_ext = {24'h0, w_byte};
      3'd5:    w_load_ext = {16'h0, w_half};
      default: w_load_ext = '0;
    endcase
    w_merge = mem_rdata;
    if (r_funct3[1:0] == 2'd0) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_funct3[1:0] == 2'd1) begin
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_funct3_nxt     = r_funct3;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_mis_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = '0;
    w_mem_wdata_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_funct3_nxt = req_funct3;
          w_addr_nxt   = req_addr;
          w_wdata_nxt  = req_wdata;
          if (!w_legal) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_mis_nxt   = 1'b1;
          end else if (!req_we) begin
            w_state_nxt    = S_LOAD;
            w_mem_addr_nxt = {req_addr[XLEN-1:2], 2'b00};
          end else if (req_funct3[1:0] == 2'd2) begin
            w_state_nxt     = S_ST_WR;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {req_addr[XLEN-1:2], 2'b00};
            w_mem_wdata_nxt = req_wdata;
          end else begin
            w_state_nxt    = S_ST_RD;
            w_mem_addr_nxt = {req_addr[XLEN-1:2], 2'b00};
          end
        end
      end
      S_LOAD: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = w_load_ext;
      end
      S_ST_RD: begin
        w_state_nxt     = S_ST_WR;
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = w_merge;
      end
      S_ST_WR: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_mis   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_funct3     <= w_funct3_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_mis   <= w_resp_mis_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_misaligned = r_resp_mis;
  assign resp_rdata      = r_resp_rdata;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed vector table, multi-cycle corner sequences and
// random requests checked against a byte-addressed reference memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT: combinational read, synchronous write
  logic [31:0] tmem [0:255];
  assign mem_rdata = tmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) tmem[mem_addr[9:2]] <= mem_wdata;

  // Reference memory as plain bytes
  logic [7:0] ref_b [0:1023];

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: size/alignment rules, byte-wise loads and stores
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic mis,
                                output int lat, output int nwe);
    int size;
    int a;
    bit legal;
    logic [31:0] val;
    size  = 1 << f3[1:0];
    a     = int'(addr[9:0]);
    legal = (f3[1:0] != 2'd3) && ((a % size) == 0) &&
            (we ? (f3[2] == 1'b0) : !(f3[2] && size == 4));
    rd = 32'h0; mis = !legal; nwe = 0; lat = 1;
    if (legal && !we) begin
      lat = 2;
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_b[a+i]) << (8*i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      rd = val;
    end else if (legal) begin
      lat = (size == 4) ? 2 : 3;
      nwe = 1;
      for (int i = 0; i < size; i++) ref_b[a+i] = wdata[8*i +: 8];
    end
  endfunction

  logic [31:0] g_rd;
  logic        g_mis;
  int          g_lat, g_nwe;

  // Issue one request, measure latency from accept, count write pulses
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    g_rd = 32'h0; g_mis = 1'b0; g_lat = 0; g_nwe = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("ready_busy", 32'(req_ready), 32'h0);
      if (mem_we) begin
        g_nwe++;
        chk("we_addr", mem_addr, {addr[31:2], 2'b00});
      end
      if (resp_valid) begin
        g_lat = c; g_rd = resp_rdata; g_mis = resp_misaligned;
        chk("resp_mem_addr", mem_addr, 32'h0);
        break;
      end
    end
    if (g_lat == 0) chk("resp_timeout", 32'(g_lat), 32'h1);
    @(negedge clk);
    chk("resp_one_cycle", {30'h0, resp_valid, req_ready}, 32'h1);
    chk("rdata_idle", resp_rdata, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
    int          exp_nwe;
  } vec_t;

  vec_t vt [16];

  logic [31:0] e_rd;
  logic        e_mis;
  int          e_lat, e_nwe;

  initial begin
    vt[0]  = '{1'b1, 3'd2, 32'h100, 32'h11223344, 32'h0,        1'b0, 2, 1};
    vt[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h11223344, 1'b0, 2, 0};
    vt[2]  = '{1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h0,        1'b0, 3, 1};
    vt[3]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h1122AB44, 1'b0, 2, 0};
    vt[4]  = '{1'b0, 3'd0, 32'h101, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};
    vt[5]  = '{1'b0, 3'd4, 32'h101, 32'h0,        32'h000000AB, 1'b0, 2, 0};
    vt[6]  = '{1'b1, 3'd1, 32'h102, 32'h00008001, 32'h0,        1'b0, 3, 1};
    vt[7]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h8001AB44, 1'b0, 2, 0};
    vt[8]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFF8001, 1'b0, 2, 0};
    vt[9]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h00008001, 1'b0, 2, 0};
    vt[10] = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0};
    vt[11] = '{1'b1, 3'd1, 32'h103, 32'h00005555, 32'h0,        1'b1, 1, 0};
    vt[12] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0};
    vt[13] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h8001AB44, 1'b0, 2, 0};
    vt[14] = '{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vt[15] = '{1'b0, 3'd4, 32'h100, 32'h0,        32'h00000044, 1'b0, 2, 0};

    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_flags", {29'h0, resp_valid, resp_misaligned, mem_we}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, e_rd, e_mis, e_lat, e_nwe);
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata);
      chk($sformatf("vec%0d_rdata", i), g_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_mis", i), 32'(g_mis), 32'(vt[i].exp_mis));
      chk($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_nwe", i), 32'(g_nwe), 32'(vt[i].exp_nwe));
    end
    chk("word_0x100", tmem[64], 32'h8001AB44);

    // Back-to-back loads with req_valid held high
    begin
      int acc [2];
      int na = 0, nr = 0;
      bit drop = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
      for (int c = 0; c < 14; c++) begin
        if (c > 0) @(negedge clk);
        if (drop) begin req_valid = 1'b0; drop = 1'b0; end
        if (resp_valid) begin
          nr++;
          chk("b2b_rdata", resp_rdata, 32'h8001AB44);
        end
        if (req_valid && req_ready) begin
          if (na < 2) acc[na] = c;
          na++;
          if (na == 2) drop = 1'b1;
        end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(na), 32'h2);
      chk("b2b_gap", 32'(acc[1] - acc[0]), 32'h3);
      chk("b2b_resps", 32'(nr), 32'h2);
    end

    // Reset pulsed while the SB is in its read phase
    begin
      int bad = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h000000EE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("strd_addr", mem_addr, 32'h100);
      rst = 1'b1;
      #1;
      chk("midrst_flags", {29'h0, resp_valid, mem_we, resp_misaligned}, 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h1);
      chk("midrst_addr", mem_addr, 32'h0);
      chk("midrst_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (resp_valid || mem_we) bad++;
      end
      chk("midrst_quiet", 32'(bad), 32'h0);
      chk("midrst_word", tmem[64], ref_word(64));
    end

    // Random requests against the reference model
    for (int n = 0; n < 80; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      if (we && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      wdata = $urandom;
      model(we, f3, addr, wdata, e_rd, e_mis, e_lat, e_nwe);
      do_req(we, f3, addr, wdata);
      chk($sformatf("rnd%0d_rdata", n), g_rd, e_rd);
      chk($sformatf("rnd%0d_mis", n), 32'(g_mis), 32'(e_mis));
      chk($sformatf("rnd%0d_lat", n), 32'(g_lat), 32'(e_lat));
      chk($sformatf("rnd%0d_nwe", n), 32'(g_nwe), 32'(e_nwe));
    end

    // Whole memory against the reference bytes
    for (int w = 0; w < 256; w++) chk($sformatf("mem_word%0d", w), tmem[w], ref_word(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
